// File: rtl/multi_issue_instr_buffer_if.sv
// Entry type and fetch/decode bus for multi_issue_instr_buffer.
// The slave modport is the buffer's view; master is the frontend/decode environment.
package multi_issue_instr_buffer_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        excp;
    logic [5:0]  excp_num;
    logic [5:0]  ftq_id;
    logic        bpu_taken;
    logic [31:0] bpu_target;
    logic        is_last_in_block;
  } instr_buffer_info_t;

endpackage

interface multi_issue_instr_buffer_if #(
  parameter int IF_WIDTH     = 2,
  parameter int DECODE_WIDTH = 2,
  parameter int DEPTH        = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                                                         flush;
  multi_issue_instr_buffer_pkg::instr_buffer_info_t [IF_WIDTH-1:0]     frontend_instr;
  logic                                                         frontend_accept;
  multi_issue_instr_buffer_pkg::instr_buffer_info_t [DECODE_WIDTH-1:0] backend_instr;
  logic [DECODE_WIDTH-1:0]                                      backend_accept;
  logic [CNT_W-1:0]                                             count;

  modport master (
    output flush, frontend_instr, backend_accept,
    input  frontend_accept, backend_instr, count
  );

  modport slave (
    input  flush, frontend_instr, backend_accept,
    output frontend_accept, backend_instr, count
  );

endinterface

// File: rtl/multi_issue_instr_buffer.sv
// Circular instruction buffer: compacts sparse fetch groups and presents the oldest entries to decode.
// Optional macro IB_BLOCK_BOUNDARY_EN stops decode issue after an entry marked is_last_in_block.
module multi_issue_instr_buffer
  import multi_issue_instr_buffer_pkg::*;
#(
  parameter int IF_WIDTH     = 2,
  parameter int DECODE_WIDTH = 2,
  parameter int DEPTH        = 16
) (
  input logic clk,
  input logic rst,
  multi_issue_instr_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] ACCEPT_LIMIT = CNT_W'(DEPTH - IF_WIDTH);

  instr_buffer_info_t mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   cnt;

  logic                                  accept;
  logic                                  push_en;
  logic [CNT_W-1:0]                      push_cnt;
  logic [CNT_W-1:0]                      pop_cnt;
  logic [PTR_W-1:0]                      slot [IF_WIDTH];
  instr_buffer_info_t [DECODE_WIDTH-1:0] present;

  // Only the registered count gates acceptance, so a same-cycle pop never frees room.
  assign accept = (cnt <= ACCEPT_LIMIT);

  always_comb begin
    logic [PTR_W-1:0] offset;
    offset   = '0;
    push_cnt = '0;
    for (int l = 0; l < IF_WIDTH; l++) begin
      slot[l] = tail + offset;
      if (bus.frontend_instr[l].valid) begin
        offset   = offset + PTR_W'(1);
        push_cnt = push_cnt + CNT_W'(1);
      end
    end
    push_en = accept && (push_cnt != '0);
  end

  always_comb begin
    logic stop;
    stop    = 1'b0;
    present = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      if (!stop && (CNT_W'(i) < cnt)) begin
        present[i] = mem[head + PTR_W'(i)];
`ifdef IB_BLOCK_BOUNDARY_EN
        stop = mem[head + PTR_W'(i)].is_last_in_block;
`endif
      end
    end
  end

  // Pop only the unbroken run of accepted, presented lanes starting at lane 0.
  always_comb begin
    logic run;
    run     = 1'b1;
    pop_cnt = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      run = run && bus.backend_accept[i] && present[i].valid;
      if (run) begin
        pop_cnt = pop_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        mem[k].valid <= 1'b0;
      end
    end else begin
      if (push_en) begin
        for (int l = 0; l < IF_WIDTH; l++) begin
          if (bus.frontend_instr[l].valid) begin
            mem[slot[l]] <= bus.frontend_instr[l];
          end
        end
        tail <= tail + push_cnt[PTR_W-1:0];
      end
      head <= head + pop_cnt[PTR_W-1:0];
      cnt  <= cnt + (push_en ? push_cnt : '0) - pop_cnt;
    end
  end

  assign bus.frontend_accept = accept;
  assign bus.backend_instr   = present;
  assign bus.count           = cnt;

endmodule

// File: tb/tb_multi_issue_instr_buffer.sv
// Bench for multi_issue_instr_buffer: vector table, directed corner sequences and a queue-model random run.
`timescale 1ns/1ps
module tb_multi_issue_instr_buffer;
  import multi_issue_instr_buffer_pkg::*;

  localparam int IFW   = 2;
  localparam int DW    = 2;
  localparam int DEPTH = 16;

  typedef instr_buffer_info_t [IFW-1:0] front_t;
  typedef instr_buffer_info_t [DW-1:0]  lanes_t;

  typedef struct {
    logic [IFW-1:0] fe_valid;
    logic [31:0]    base_pc;
    logic [DW-1:0]  acc;
    logic           flush;
    int             exp_count;
    logic           exp_accept;
    logic           exp_v0;
    logic [31:0]    exp_pc0;
    logic           exp_v1;
    logic [31:0]    exp_pc1;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_issue_instr_buffer_if #(.IF_WIDTH(IFW), .DECODE_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  multi_issue_instr_buffer #(.IF_WIDTH(IFW), .DECODE_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  instr_buffer_info_t model_q[$];
  int total = 0;
  int bad   = 0;
  vec_t vecs [8];

  function automatic instr_buffer_info_t make_entry(logic v, logic [31:0] pc, logic last);
    instr_buffer_info_t e = '0;
    e.valid            = v;
    e.pc               = pc;
    e.instr            = pc ^ 32'h0013_0000;
    e.ftq_id           = pc[7:2];
    e.is_last_in_block = last;
    return e;
  endfunction

  function automatic instr_buffer_info_t rand_entry(logic v);
    instr_buffer_info_t e;
    e.valid            = v;
    e.pc               = $urandom;
    e.instr            = $urandom;
    e.excp             = 1'($urandom);
    e.excp_num         = 6'($urandom);
    e.ftq_id           = 6'($urandom);
    e.bpu_taken        = 1'($urandom);
    e.bpu_target       = $urandom;
    e.is_last_in_block = ($urandom_range(0, 3) == 0);
    return e;
  endfunction

  function automatic front_t group(logic [IFW-1:0] mask, logic [31:0] base);
    front_t g;
    for (int l = 0; l < IFW; l++) g[l] = make_entry(mask[l], base + 32'(4 * l), 1'b0);
    return g;
  endfunction

  // Decode sees the oldest entries in order, cut short after a block end when the boundary feature is built in.
  function automatic lanes_t model_present();
    lanes_t lanes = '0;
    for (int i = 0; i < DW; i++) begin
      if (i >= model_q.size()) break;
      lanes[i] = model_q[i];
`ifdef IB_BLOCK_BOUNDARY_EN
      if (model_q[i].is_last_in_block) break;
`endif
    end
    return lanes;
  endfunction

  task automatic apply_stimulus(input front_t fe, input logic [DW-1:0] acc, input logic fl, input logic rs);
    lanes_t pres;
    int     pops;
    int     room;
    bus.frontend_instr = fe;
    bus.backend_accept = acc;
    bus.flush          = fl;
    rst                = rs;
    pres = model_present();
    room = ((DEPTH - model_q.size()) >= IFW) ? 1 : 0;
    pops = 0;
    for (int i = 0; i < DW; i++) begin
      if (acc[i] && pres[i].valid) pops++;
      else break;
    end
    @(posedge clk);
    if (rs || fl) begin
      model_q.delete();
    end else begin
      repeat (pops) void'(model_q.pop_front());
      if (room != 0) begin
        for (int l = 0; l < IFW; l++) if (fe[l].valid) model_q.push_back(fe[l]);
      end
    end
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic check_output(input string tag);
    lanes_t exp = model_present();
    check({tag, " count"}, 128'(bus.count), 128'(model_q.size()));
    check({tag, " accept"}, 128'(bus.frontend_accept), 128'((DEPTH - model_q.size()) >= IFW));
    for (int i = 0; i < DW; i++)
      check($sformatf("%s lane%0d", tag, i), 128'(bus.backend_instr[i]), 128'(exp[i]));
  endtask

  initial begin
    front_t      fe;
    logic [31:0] pc;
    logic [31:0] exp_pc;
    int          len;

    vecs[0] = '{2'b11, 32'h1c00_0000, 2'b00, 1'b0, 2, 1'b1, 1'b1, 32'h1c00_0000, 1'b1, 32'h1c00_0004};
    vecs[1] = '{2'b00, 32'h0000_0000, 2'b11, 1'b0, 0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000};
    vecs[2] = '{2'b10, 32'h1c00_0010, 2'b00, 1'b0, 1, 1'b1, 1'b1, 32'h1c00_0014, 1'b0, 32'h0000_0000};
    vecs[3] = '{2'b01, 32'h1c00_0020, 2'b01, 1'b0, 1, 1'b1, 1'b1, 32'h1c00_0020, 1'b0, 32'h0000_0000};
    vecs[4] = '{2'b11, 32'h1c00_0030, 2'b10, 1'b0, 3, 1'b1, 1'b1, 32'h1c00_0020, 1'b1, 32'h1c00_0030};
    vecs[5] = '{2'b00, 32'h0000_0000, 2'b11, 1'b1, 0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000};
    vecs[6] = '{2'b11, 32'h1c00_0040, 2'b11, 1'b0, 2, 1'b1, 1'b1, 32'h1c00_0040, 1'b1, 32'h1c00_0044};
    vecs[7] = '{2'b11, 32'h1c00_0050, 2'b01, 1'b0, 3, 1'b1, 1'b1, 32'h1c00_0044, 1'b1, 32'h1c00_0050};

    rst                = 1'b1;
    bus.flush          = 1'b0;
    bus.frontend_instr = '0;
    bus.backend_accept = '0;
    apply_stimulus('0, '0, 1'b0, 1'b1);
    apply_stimulus('0, '0, 1'b0, 1'b1);
    check("reset count", 128'(bus.count), 128'(0));
    check("reset accept", 128'(bus.frontend_accept), 128'(1));
    check("reset lanes", 128'(bus.backend_instr), 128'(0));
    apply_stimulus('0, '0, 1'b0, 1'b0);

    $display("[TB] vector table");
    for (int v = 0; v < 8; v++) begin
      apply_stimulus(group(vecs[v].fe_valid, vecs[v].base_pc), vecs[v].acc, vecs[v].flush, 1'b0);
      check($sformatf("vec%0d count", v), 128'(bus.count), 128'(vecs[v].exp_count));
      check($sformatf("vec%0d accept", v), 128'(bus.frontend_accept), 128'(vecs[v].exp_accept));
      check($sformatf("vec%0d v0", v), 128'(bus.backend_instr[0].valid), 128'(vecs[v].exp_v0));
      check($sformatf("vec%0d pc0", v), 128'(bus.backend_instr[0].pc), 128'(vecs[v].exp_pc0));
      check($sformatf("vec%0d v1", v), 128'(bus.backend_instr[1].valid), 128'(vecs[v].exp_v1));
      check($sformatf("vec%0d pc1", v), 128'(bus.backend_instr[1].pc), 128'(vecs[v].exp_pc1));
    end

    $display("[TB] fill to full");
    apply_stimulus('0, '0, 1'b0, 1'b1);
    for (int g = 0; g < 8; g++) apply_stimulus(group(2'b11, 32'h1c00_1000 + 32'(8 * g)), 2'b00, 1'b0, 1'b0);
    check("full count", 128'(bus.count), 128'(16));
    check("full accept", 128'(bus.frontend_accept), 128'(0));
    apply_stimulus(group(2'b11, 32'h1c00_2000), 2'b00, 1'b0, 1'b0);
    check("full ignore count", 128'(bus.count), 128'(16));
    check("full ignore pc0", 128'(bus.backend_instr[0].pc), 128'(32'h1c00_1000));
    apply_stimulus('0, 2'b11, 1'b0, 1'b0);
    check("drain count", 128'(bus.count), 128'(14));
    check("drain accept", 128'(bus.frontend_accept), 128'(1));
    check_output("drain");

    $display("[TB] steady stream across wrap");
    apply_stimulus('0, '0, 1'b0, 1'b1);
    pc = 32'h1c00_3000;
    apply_stimulus(group(2'b11, pc), 2'b00, 1'b0, 1'b0);
    exp_pc = pc;
    pc     = pc + 32'd8;
    for (int n = 0; n < 40; n++) begin
      check($sformatf("stream%0d pc0", n), 128'(bus.backend_instr[0].pc), 128'(exp_pc));
      check($sformatf("stream%0d pc1", n), 128'(bus.backend_instr[1].pc), 128'(exp_pc + 32'd4));
      check($sformatf("stream%0d count", n), 128'(bus.count), 128'(2));
      apply_stimulus(group(2'b11, pc), 2'b11, 1'b0, 1'b0);
      pc     = pc + 32'd8;
      exp_pc = exp_pc + 32'd8;
    end

    $display("[TB] flush and reset with traffic");
    for (int mode = 0; mode < 2; mode++) begin
      apply_stimulus('0, '0, 1'b0, 1'b1);
      for (int g = 0; g < 3; g++) apply_stimulus(group(2'b11, 32'h1c00_4000 + 32'(8 * g)), 2'b00, 1'b0, 1'b0);
      check($sformatf("clear%0d pre count", mode), 128'(bus.count), 128'(6));
      apply_stimulus(group(2'b11, 32'h1c00_4100), 2'b11, (mode == 0), (mode == 1));
      check($sformatf("clear%0d count", mode), 128'(bus.count), 128'(0));
      check($sformatf("clear%0d accept", mode), 128'(bus.frontend_accept), 128'(1));
      check($sformatf("clear%0d v0", mode), 128'(bus.backend_instr[0].valid), 128'(0));
      check($sformatf("clear%0d v1", mode), 128'(bus.backend_instr[1].valid), 128'(0));
    end

    $display("[TB] block boundary");
    apply_stimulus('0, '0, 1'b0, 1'b1);
    fe[0] = make_entry(1'b1, 32'h1c00_5000, 1'b1);
    fe[1] = make_entry(1'b1, 32'h1c00_5004, 1'b0);
    apply_stimulus(fe, 2'b00, 1'b0, 1'b0);
    check("block A pc", 128'(bus.backend_instr[0].pc), 128'(32'h1c00_5000));
`ifdef IB_BLOCK_BOUNDARY_EN
    check("block lane1 hidden", 128'(bus.backend_instr[1]), 128'(0));
    apply_stimulus('0, 2'b11, 1'b0, 1'b0);
    check("block pop count", 128'(bus.count), 128'(1));
    check("block B lane0", 128'(bus.backend_instr[0].pc), 128'(32'h1c00_5004));
`else
    check("block lane1 B", 128'(bus.backend_instr[1].pc), 128'(32'h1c00_5004));
    apply_stimulus('0, 2'b11, 1'b0, 1'b0);
    check("block pop count", 128'(bus.count), 128'(0));
`endif

    $display("[TB] random traffic");
    apply_stimulus('0, '0, 1'b0, 1'b1);
    for (int n = 0; n < 600; n++) begin
      for (int l = 0; l < IFW; l++) fe[l] = rand_entry(1'($urandom));
      if (((n / 50) % 2) == 0) len = ($urandom_range(0, 4) == 0) ? 1 : 0;
      else len = $urandom_range(0, DW);
      apply_stimulus(fe, DW'((1 << len) - 1), ($urandom_range(0, 63) == 0), 1'b0);
      check_output($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_issue_instr_buffer.md
Name: multi_issue_instr_buffer

Overview:
Parametrised instruction buffer between the IFU and the ID stage.
- Accepts up to IF_WIDTH `instr_buffer_info_t` entries per cycle and presents up to DECODE_WIDTH entries per cycle to decode.
- Replaces the fixed 2-wide decode coupling with independent fetch and decode widths and a configurable depth.
- Provides flush support and in-order compaction of sparse fetch groups.

Parameters:
- IF_WIDTH, 2, number of fetch lanes written per cycle (1..4)
- DECODE_WIDTH, 2, number of decode lanes presented per cycle (1..4)
- DEPTH, 16, entry count; power of two, >= IF_WIDTH + DECODE_WIDTH

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- flush_i  in  1  backend redirect; discards all buffered entries
- frontend_instr_i  in  IF_WIDTH x instr_buffer_info_t  fetch group; per-lane `.valid` marks a present instruction
- frontend_accept_o  out  1  buffer can take a full group this cycle
- backend_instr_o  out  DECODE_WIDTH x instr_buffer_info_t  oldest entries, lane 0 = oldest
- backend_accept_i  in  DECODE_WIDTH  decode consumes lanes; must be a prefix mask (1..1 0..0)
- count_o  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
Interface constraints:
- Single clock domain: clk.
- Reset (rst) is synchronous and active-high.

Reset and flush:
- On rst, all storage valid bits = 0, head = tail = 0, count_o = 0, frontend_accept_o = 1, and every backend_instr_o[i].valid = 0.
- flush_i is equivalent to rst for pointers, count and valid bits.
- flush_i has priority over push and pop in the same cycle; the incoming group is dropped.

Accept:
- frontend_accept_o = (DEPTH - count) >= IF_WIDTH.
- It is combinational from registered count only; space freed by a same-cycle pop is not counted.

Push:
- Push occurs when frontend_accept_o is high and at least one lane has `.valid` set.
- Valid lanes are compacted in lane order: the k-th valid lane is written to slot tail+k mod DEPTH.
- Invalid lanes are discarded; any valid pattern is legal, e.g. 0b1010.
- push_cnt = popcount(valid lanes). Tail advances by push_cnt with wrap modulo DEPTH.
- If frontend_accept_o is low, the group is ignored; holding the group is the frontend's job.

Read:
- backend_instr_o[i] = entry at head+i mod DEPTH when i < count; otherwise all fields are zero.
- Outputs come combinationally from registered storage and pointers; there is no write-to-read bypass.
- A pushed entry appears on backend_instr_o at the earliest in the cycle after the push.

Pop:
- pop_cnt = number of leading ones of (backend_accept_i & presented valid).
- A non-prefix backend_accept_i is illegal; its bits after the first zero are ignored.
- Head advances by pop_cnt modulo DEPTH.

Count:
- count_next = count + push_cnt - pop_cnt, evaluated in the same cycle.
- Full occupancy (count = DEPTH) is reachable; count never exceeds DEPTH because of the accept rule.
- Pointers are $clog2(DEPTH) bits and wrap naturally.

Storage:
- Entries are stored unmodified; the excp, excp_num, ftq_id and BPU fields pass through bit-exact.

Optional Feature:
Macro: IB_BLOCK_BOUNDARY_EN
- Defined: decode issue stops at a basic-block boundary. If presented lane j has `.is_last_in_block` = 1, lanes j+1..DECODE_WIDTH-1 are presented with `.valid` = 0 and all fields zero that cycle. pop_cnt is limited to j+1 accordingly. The following entries present from lane 0 in a later cycle.
- Not defined: `.is_last_in_block` is ignored for issue; all lanes up to count are presented.

Test Plan:
1. Reset, then push pcs 0x1c000000/0x1c000004 (valid 0b11) in cycle 0 with backend_accept_i = 0 -> cycle 1: count_o = 2, lane0.pc = 0x1c000000, lane1.pc = 0x1c000004, frontend_accept_o = 1.
2. Push a group with valid 0b10, pc 0x1c000014 on lane 1, into an empty buffer -> next cycle: lane0.pc = 0x1c000014, lane0.valid = 1, lane1.valid = 0, count_o = 1.
3. DEPTH = 16: push 8 full groups with no pops -> count_o = 16, frontend_accept_o = 0. A 9th group is ignored and count stays 16. Then backend_accept_i = 0b11 for 1 cycle -> count_o = 14, accept_o = 1.
4. Steady push 2 / pop 2 for 40 cycles with incrementing pcs -> output pc sequence strictly +4 each instruction across pointer wrap, count_o constant at 2, no gaps or duplicates.
5. count = 6 with a simultaneous push of 2, backend_accept_i = 0b11 and flush_i = 1 -> next cycle: count_o = 0, all backend valid = 0, frontend_accept_o = 1. Repeat the scenario using rst instead of flush_i -> identical result.
6. With IB_BLOCK_BOUNDARY_EN defined, entries A(last = 1), B -> cycle 1 presents only A (lane1.valid = 0); accept 0b11 pops 1. Next cycle B is on lane 0. Without the macro, A and B are presented together and both pop.
